// File: rtl/voice_template_loader.sv
// Copies the recorded sample buffer into one of four direction template RAMs
// and tracks which templates hold a complete copy.
module voice_template_loader #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32,
    parameter int CHUNKS = 2830,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        dir,
    input  logic              abort,
    input  logic              rec_busy,
    output logic [ADDR_W-1:0] src_addr,
    input  logic [DATA_W-1:0] src_data,
    output logic [3:0]        dst_we,
    output logic [ADDR_W-1:0] dst_addr,
    output logic [DATA_W-1:0] dst_data,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [3:0]        valid_mask
);

    // state | meaning
    // IDLE  | waiting for start
    // READ  | issuing one source read per cycle
    // DRAIN | waiting for the last RD_LAT reads to land
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] READ  = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    // CHUNKS may equal 2**ADDR_W, so compare against the last address, not CHUNKS
    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(CHUNKS - 1);
    localparam logic [1:0]        DRAIN_LAST = 2'(RD_LAT - 1);

    logic [1:0]        state;
    logic [1:0]        dir_q;
    logic [ADDR_W-1:0] rd_cnt;
    logic [1:0]        drain_cnt;
    logic [RD_LAT-1:0] vld_pipe;
    logic [ADDR_W-1:0] addr_pipe [RD_LAT];
    logic              tail_vld;

    assign tail_vld = vld_pipe[RD_LAT-1];
    assign src_addr = rd_cnt;
    assign busy     = (state != IDLE);
    assign dst_we   = tail_vld ? (4'b0001 << dir_q) : 4'b0000;
    assign dst_addr = tail_vld ? addr_pipe[RD_LAT-1] : '0;
    assign dst_data = tail_vld ? src_data : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            dir_q      <= 2'd0;
            rd_cnt     <= '0;
            drain_cnt  <= 2'd0;
            vld_pipe   <= '0;
            done       <= 1'b0;
            err        <= 1'b0;
            valid_mask <= 4'b0000;
            for (int i = 0; i < RD_LAT; i++) addr_pipe[i] <= '0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;

            vld_pipe[0]  <= (state == READ);
            addr_pipe[0] <= rd_cnt;
            for (int i = 1; i < RD_LAT; i++) begin
                vld_pipe[i]  <= vld_pipe[i-1];
                addr_pipe[i] <= addr_pipe[i-1];
            end

            case (state)
                IDLE: begin
                    if (start && !abort) begin
                        if (rec_busy) begin
                            err <= 1'b1;
                        end else begin
                            dir_q           <= dir;
                            rd_cnt          <= '0;
                            valid_mask[dir] <= 1'b0;
                            state           <= READ;
                        end
                    end
                end
                READ: begin
                    if (abort) begin
                        state    <= IDLE;
                        rd_cnt   <= '0;
                        vld_pipe <= '0;
                    end else begin
                        if (start) err <= 1'b1;
                        if (rd_cnt == LAST_ADDR) begin
                            state     <= DRAIN;
                            drain_cnt <= 2'd0;
                        end else begin
                            rd_cnt <= rd_cnt + ADDR_W'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (abort) begin
                        state    <= IDLE;
                        rd_cnt   <= '0;
                        vld_pipe <= '0;
                    end else begin
                        if (start) err <= 1'b1;
                        if (drain_cnt == DRAIN_LAST) begin
                            state             <= IDLE;
                            rd_cnt            <= '0;
                            done              <= 1'b1;
                            valid_mask[dir_q] <= 1'b1;
                        end else begin
                            drain_cnt <= drain_cnt + 2'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_voice_template_loader.sv
// Directed bench for voice_template_loader with CHUNKS=8 at RD_LAT=1 and RD_LAT=3.
module tb_voice_template_loader;

    localparam int ADDR_W = 12;
    localparam int DATA_W = 32;
    localparam int CHUNKS = 8;

    logic clk;
    logic rst;
    logic start1, start3;
    logic [1:0] dir;
    logic abort;
    logic rec_busy;

    logic [ADDR_W-1:0] src_addr1, src_addr3, dst_addr1, dst_addr3;
    logic [DATA_W-1:0] src_data1, src_data3, dst_data1, dst_data3;
    logic [3:0]        dst_we1, dst_we3, mask1, mask3;
    logic              busy1, busy3, done1, done3, err1, err3;

    logic [ADDR_W-1:0] rd1_q;
    logic [ADDR_W-1:0] rd3_q [3];

    int tests = 0;
    int fails = 0;

    logic              sel;
    logic [ADDR_W-1:0] obs_src_addr, obs_dst_addr;
    logic [DATA_W-1:0] obs_dst_data;
    logic [3:0]        obs_we, obs_mask;
    logic              obs_busy, obs_done, obs_err;

    voice_template_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CHUNKS(CHUNKS), .RD_LAT(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .dir(dir), .abort(abort), .rec_busy(rec_busy),
        .src_addr(src_addr1), .src_data(src_data1), .dst_we(dst_we1), .dst_addr(dst_addr1),
        .dst_data(dst_data1), .busy(busy1), .done(done1), .err(err1), .valid_mask(mask1)
    );

    voice_template_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CHUNKS(CHUNKS), .RD_LAT(3)) dut3 (
        .clk(clk), .rst(rst), .start(start3), .dir(dir), .abort(abort), .rec_busy(rec_busy),
        .src_addr(src_addr3), .src_data(src_data3), .dst_we(dst_we3), .dst_addr(dst_addr3),
        .dst_data(dst_data3), .busy(busy3), .done(done3), .err(err3), .valid_mask(mask3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Sample RAM models: word at address a reads back as a + 0xA0
    always @(posedge clk) begin
        rd1_q    <= src_addr1;
        rd3_q[0] <= src_addr3;
        rd3_q[1] <= rd3_q[0];
        rd3_q[2] <= rd3_q[1];
    end
    assign src_data1 = {20'd0, rd1_q} + 32'hA0;
    assign src_data3 = {20'd0, rd3_q[2]} + 32'hA0;

    assign obs_src_addr = sel ? src_addr3 : src_addr1;
    assign obs_dst_addr = sel ? dst_addr3 : dst_addr1;
    assign obs_dst_data = sel ? dst_data3 : dst_data1;
    assign obs_we       = sel ? dst_we3   : dst_we1;
    assign obs_mask     = sel ? mask3     : mask1;
    assign obs_busy     = sel ? busy3     : busy1;
    assign obs_done     = sel ? done3     : done1;
    assign obs_err      = sel ? err3      : err1;

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests++;
        assert (observed === expected)
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic set_start(input logic v);
        if (sel) start3 = v; else start1 = v;
    endtask

    // One copy with per-cycle expectations; cycle 0 is the cycle start is high.
    task automatic copy_check(input logic s, input int lat, input logic [1:0] d,
                              input logic [3:0] m0, input int abort_c, input int inj_c);
        logic [3:0] bit_d;
        int         last_busy;
        int         done_c;
        bit         wr;
        int         a;
        sel   = s;
        bit_d = 4'b0001 << d;
        done_c    = CHUNKS + lat + 1;
        last_busy = (abort_c != 0) ? abort_c : CHUNKS + lat;
        dir = d;
        set_start(1'b1);
        for (int c = 1; c <= CHUNKS + lat + 3; c++) begin
            @(negedge clk);
            wr = (c >= lat + 1) && (c <= lat + CHUNKS) && (abort_c == 0 || c <= abort_c);
            a  = c - lat - 1;
            chk($sformatf("dst_we c%0d", c), {28'd0, obs_we}, wr ? {28'd0, bit_d} : 32'd0);
            if (wr) begin
                chk($sformatf("dst_addr c%0d", c), {20'd0, obs_dst_addr}, a);
                chk($sformatf("dst_data c%0d", c), obs_dst_data, 32'hA0 + a);
            end
            if (c <= CHUNKS && (abort_c == 0 || c <= abort_c))
                chk($sformatf("src_addr c%0d", c), {20'd0, obs_src_addr}, c - 1);
            chk($sformatf("busy c%0d", c), {31'd0, obs_busy}, (c <= last_busy) ? 1 : 0);
            chk($sformatf("done c%0d", c), {31'd0, obs_done}, (abort_c == 0 && c == done_c) ? 1 : 0);
            chk($sformatf("err c%0d", c), {31'd0, obs_err}, (inj_c != 0 && c == inj_c + 1) ? 1 : 0);
            chk($sformatf("mask c%0d", c), {28'd0, obs_mask},
                (abort_c == 0 && c >= done_c) ? {28'd0, m0 | bit_d} : {28'd0, m0 & ~bit_d});
            if (c == 1) set_start(1'b0);
            if (c == abort_c) abort = 1'b1;
            if (abort_c != 0 && c == abort_c + 1) abort = 1'b0;
            if (inj_c != 0 && c == inj_c) begin
                set_start(1'b1);
                dir = 2'd3;
            end
            if (inj_c != 0 && c == inj_c + 1) set_start(1'b0);
        end
    endtask

    initial begin
        rst = 1'b1; start1 = 1'b0; start3 = 1'b0; dir = 2'd0;
        abort = 1'b0; rec_busy = 1'b0; sel = 1'b0;

        @(negedge clk);
        chk("reset busy", {31'd0, busy1}, 0);
        chk("reset mask", {28'd0, mask1}, 0);
        chk("reset we", {28'd0, dst_we1}, 0);
        chk("reset src_addr", {20'd0, src_addr1}, 0);
        chk("reset done/err", {30'd0, done1, err1}, 0);
        rst = 1'b0;
        @(negedge clk);

        // Preset mask bit 1, then abort a second copy to dir 1 after its 4th write
        copy_check(1'b0, 1, 2'd1, 4'b0000, 0, 0);
        copy_check(1'b0, 1, 2'd1, 4'b0010, 5, 0);
        chk("abort final mask", {28'd0, mask1}, 0);

        // Basic copy, RD_LAT=1, dir 2
        copy_check(1'b0, 1, 2'd2, 4'b0000, 0, 0);

        // Start rejected while the recorder owns the RAM
        sel = 1'b0;
        rec_busy = 1'b1; dir = 2'd0; start1 = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            chk($sformatf("recbusy err c%0d", c), {31'd0, err1}, (c == 1) ? 1 : 0);
            chk($sformatf("recbusy busy c%0d", c), {31'd0, busy1}, 0);
            chk($sformatf("recbusy we c%0d", c), {28'd0, dst_we1}, 0);
            chk($sformatf("recbusy mask c%0d", c), {28'd0, mask1}, 32'h4);
            if (c == 1) begin start1 = 1'b0; rec_busy = 1'b0; end
        end

        // start together with abort is ignored without err
        start1 = 1'b1; abort = 1'b1; dir = 2'd2;
        @(negedge clk);
        start1 = 1'b0; abort = 1'b0;
        chk("start+abort err", {31'd0, err1}, 0);
        chk("start+abort busy", {31'd0, busy1}, 0);
        chk("start+abort mask", {28'd0, mask1}, 32'h4);

        // RD_LAT=3 copy to dir 0, then a second copy with a dir 3 start injected mid-copy
        copy_check(1'b1, 3, 2'd0, 4'b0000, 0, 0);
        copy_check(1'b1, 3, 2'd0, 4'b0001, 0, 4);

        // Asynchronous reset mid-READ, then a clean copy
        sel = 1'b0;
        dir = 2'd2; start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("pre-reset busy", {31'd0, busy1}, 1);
        #2 rst = 1'b1;
        #1;
        chk("async rst busy", {31'd0, busy1}, 0);
        chk("async rst we", {28'd0, dst_we1}, 0);
        chk("async rst mask", {28'd0, mask1}, 0);
        chk("async rst src_addr", {20'd0, src_addr1}, 0);
        chk("async rst dst_addr/data", {20'd0, dst_addr1} | dst_data1, 0);
        chk("async rst done/err", {30'd0, done1, err1}, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        copy_check(1'b0, 1, 2'd2, 4'b0000, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
